// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_e;

  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/arb_timeout_timer.sv
// Per-access watchdog: expired is high in the cycle the count reaches TIMEOUT-1.
module arb_timeout_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // expired is registered by looking one count ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= (LAST == '0);
    end else if (run) begin
      count   <= count + TIMER_W'(1);
      expired <= ((count + TIMER_W'(1)) == LAST);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU instruction-fetch and data accesses onto one variable-latency RAM,
// MEM first, with a watchdog that aborts accesses whose ack never arrives.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_ack,
  output logic              bus_err,
  output logic              err_src
);

  arb_state_e        state_q, state_d;
  logic              ram_cs_d, ram_we_d, inst_ready_d, mem_ready_d, bus_err_d, err_src_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d, inst_data_d, mem_din_d;
  logic              mem_req_c, if_req_c, grant_c, run_c, expired;
  logic [DATA_W-1:0] resp_data_c;

  // A requester showing its ready pulse has just been served and is masked.
  assign mem_req_c   = (mem_ren | mem_wen) & ~mem_ready;
  assign if_req_c    = inst_ren & ~inst_ready;
  assign stall_if    = inst_ren & ~inst_ready;
  assign stall_mem   = (mem_ren | mem_wen) & ~mem_ready;
  assign run_c       = (state_q != IDLE) & ~ram_ack;
  assign resp_data_c = ram_ack ? ram_dout : ERR_DATA;

  arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant_c),
    .run     (run_c),
    .expired (expired)
  );

  // Grant, completion and abort decisions.
  always_comb begin
    state_d      = state_q;
    ram_cs_d     = ram_cs;
    ram_we_d     = ram_we;
    ram_addr_d   = ram_addr;
    ram_din_d    = ram_din;
    inst_data_d  = inst_data;
    mem_din_d    = mem_din;
    inst_ready_d = 1'b0;
    mem_ready_d  = 1'b0;
    bus_err_d    = bus_err;
    err_src_d    = err_src;
    grant_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_c) begin
          grant_c    = 1'b1;
          state_d    = BUSY_MEM;
          ram_cs_d   = 1'b1;
          ram_we_d   = mem_wen;
          ram_addr_d = mem_addr;
          ram_din_d  = mem_dout;
        end else if (if_req_c) begin
          grant_c    = 1'b1;
          state_d    = BUSY_IF;
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = inst_addr;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (ram_ack || expired) begin
          state_d  = IDLE;
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
          if (state_q == BUSY_IF) begin
            inst_ready_d = 1'b1;
            inst_data_d  = resp_data_c;
          end else begin
            mem_ready_d = 1'b1;
            if (!ram_we) mem_din_d = resp_data_c;
          end
          if (!ram_ack) begin
            bus_err_d = 1'b1;
            err_src_d = (state_q == BUSY_MEM) ? SRC_MEM : SRC_IF;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      inst_data  <= '0;
      mem_din    <= '0;
      inst_ready <= 1'b0;
      mem_ready  <= 1'b0;
      bus_err    <= 1'b0;
      err_src    <= SRC_IF;
    end else begin
      state_q    <= state_d;
      ram_cs     <= ram_cs_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_din    <= ram_din_d;
      inst_data  <= inst_data_d;
      mem_din    <= mem_din_d;
      inst_ready <= inst_ready_d;
      mem_ready  <= mem_ready_d;
      bus_err    <= bus_err_d;
      err_src    <= err_src_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with an address-driven RAM model.
module tb_mem_port_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_ren, mem_ren, mem_wen;
  logic [31:0] inst_addr, mem_addr, mem_dout;
  logic [31:0] inst_data, mem_din, ram_addr, ram_din, ram_dout;
  logic        inst_ready, mem_ready, stall_if, stall_mem;
  logic        ram_cs, ram_we, ram_ack, bus_err, err_src;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ready(inst_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready), .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ack(ram_ack), .bus_err(bus_err), .err_src(err_src)
  );

  typedef struct {
    logic [31:0] data;
    bit          to;
  } exp_t;

  exp_t        if_q[$];
  exp_t        mem_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          if_issued = 0, if_granted = 0, if_issue_cyc = 0, last_if_ready_cyc = 0;
  int          mem_issued = 0, mem_granted = 0, mem_issue_cyc = 0;
  logic [31:0] mem_last = 32'h0;
  bit          exp_err = 1'b0;
  bit          exp_src = 1'b0;
  bit          prev_cs = 1'b0;
  int          cs_len = 0, acc_lat = 0;
  logic        hold_we;
  logic [31:0] hold_addr, hold_din;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: ack cycle is a function of the address; latency 9 never acks in time.
  function automatic int lat_of(input logic [31:0] a);
    return (a[5:2] >= 4'd13) ? 9 : int'(a[3:2]) + 1;
  endfunction

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic bit times_out(input logic [31:0] a);
    return lat_of(a) > int'(TO);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Responder; a timed-out access gets a late ack in the first cycle after ram_cs drops.
  initial begin : ram_model
    int cnt;
    int lat;
    cnt = 0;
    lat = 0;
    ram_ack = 1'b0;
    ram_dout = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (ram_cs) begin
        cnt++;
        lat = lat_of(ram_addr);
        ram_ack = (cnt == lat);
      end else begin
        ram_ack = (cnt == int'(TO)) && (lat > int'(TO));
        cnt = 0;
      end
      ram_dout = ram_ack ? hash(ram_addr) : $urandom;
    end
  end

  // Monitor: grant order, RAM bus stability, ready/data scoreboard, error flags, stalls.
  always @(negedge clk) begin
    if (inst_ready) check("stall_if_ready", 32'(stall_if), 32'd0);
    else            check("stall_if", 32'(stall_if), 32'(inst_ren));
    if (mem_ready)  check("stall_mem_ready", 32'(stall_mem), 32'd0);
    else            check("stall_mem", 32'(stall_mem), 32'(mem_ren | mem_wen));

    if (rst_n && ram_cs && !prev_cs) begin
      if (mem_issued > mem_granted && mem_issue_cyc < cyc) begin
        mem_granted++;
        check("grant_mem_we", 32'(ram_we), 32'(mem_wen));
        check("grant_mem_addr", ram_addr, mem_addr);
        if (mem_wen) check("grant_mem_din", ram_din, mem_dout);
      end else if (if_issued > if_granted && if_issue_cyc < cyc) begin
        if_granted++;
        check("grant_if_we", 32'(ram_we), 32'd0);
        check("grant_if_addr", ram_addr, inst_addr);
      end else begin
        note_fail("spurious_grant");
      end
      hold_we = ram_we;
      hold_addr = ram_addr;
      hold_din = ram_din;
      cs_len = 1;
      acc_lat = lat_of(ram_addr);
    end else if (ram_cs) begin
      cs_len++;
      check("hold_we", 32'(ram_we), 32'(hold_we));
      check("hold_addr", ram_addr, hold_addr);
      check("hold_din", ram_din, hold_din);
    end else if (prev_cs && rst_n) begin
      check("cs_len", 32'(cs_len), 32'((acc_lat < int'(TO)) ? acc_lat : int'(TO)));
    end
    prev_cs = ram_cs;

    if (inst_ready) begin
      last_if_ready_cyc = cyc;
      if (if_q.size() == 0) note_fail("spurious_inst_ready");
      else begin
        mon_e = if_q.pop_front();
        check("inst_data", inst_data, mon_e.data);
        if (mon_e.to) begin exp_err = 1'b1; exp_src = 1'b0; end
      end
    end
    if (mem_ready) begin
      if (mem_q.size() == 0) note_fail("spurious_mem_ready");
      else begin
        mon_e = mem_q.pop_front();
        check("mem_din", mem_din, mon_e.data);
        if (mon_e.to) begin exp_err = 1'b1; exp_src = 1'b1; end
      end
    end
    check("bus_err", 32'(bus_err), 32'(exp_err));
    if (exp_err) check("err_src", 32'(err_src), 32'(exp_src));
  end

  // Requester tasks start and end at posedge+1.
  task automatic if_req(input logic [31:0] a);
    exp_t e;
    int n;
    e.data = times_out(a) ? ERR : hash(a);
    e.to = times_out(a);
    if_q.push_back(e);
    inst_addr = a;
    inst_ren = 1'b1;
    if_issue_cyc = cyc;
    if_issued++;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (inst_ready) break;
    end
    if (!inst_ready) note_fail("inst_ready_wait_expired");
    @(posedge clk);
    #1;
    inst_ren = 1'b0;
    inst_addr = $urandom;
  endtask

  task automatic mem_req(input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    e.to = times_out(a);
    if (we) e.data = mem_last;
    else begin
      e.data = e.to ? ERR : hash(a);
      mem_last = e.data;
    end
    mem_q.push_back(e);
    mem_addr = a;
    mem_dout = d;
    mem_wen = we;
    mem_ren = we ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_issue_cyc = cyc;
    mem_issued++;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (mem_ready) break;
    end
    if (!mem_ready) note_fail("mem_ready_wait_expired");
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    mem_addr = $urandom;
    mem_dout = $urandom;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    inst_ren = 1'b0; inst_addr = 32'h0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_readies", 32'({inst_ready, mem_ready}), 32'd0);
    check("rst_err", 32'({bus_err, err_src}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while an IF access is in flight.
    @(posedge clk); #1;
    inst_addr = 32'h0000_003C;
    inst_ren = 1'b1;
    if_issue_cyc = cyc;
    if_issued++;
    @(negedge clk); @(negedge clk);
    check("midrst_cs_before", 32'(ram_cs), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    inst_ren = 1'b0;
    @(negedge clk);
    check("midrst_cs", 32'(ram_cs), 32'd0);
    check("midrst_ready", 32'(inst_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    if_req(32'h0000_0000);
    check("min_latency", 32'(last_if_ready_cyc - if_issue_cyc), 32'd2);
    if_req(32'h0000_0014);
    check("fetch_latency", 32'(last_if_ready_cyc - if_issue_cyc), 32'd3);
    fork
      if_req(32'h0000_0040);
      mem_req(1'b0, 32'h0000_0040, 32'h0);
    join
    check("if_after_mem_latency", 32'(last_if_ready_cyc - if_issue_cyc), 32'd4);
    mem_req(1'b1, 32'h0000_0088, 32'hDEAD_BEEF);
    if_req(32'h0000_000C);
    mem_req(1'b0, 32'h0000_003C, 32'h0);
    if_req(32'h0000_0020);

    fork
      begin
        for (int i = 0; i < 150; i++) begin
          int gap;
          logic [31:0] a;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          a = $urandom;
          a[1:0] = 2'b00;
          if_req(a);
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          int gap;
          logic [31:0] a;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          a = $urandom;
          a[1:0] = 2'b00;
          mem_req(1'($urandom_range(0, 1)), a, $urandom);
        end
      end
    join

    repeat (10) @(negedge clk);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("if_grants", 32'(if_granted), 32'(if_issued));
    check("mem_grants", 32'(mem_granted), 32'(mem_issued));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
